bist_sequencer: RTL and testbench
=================================

# bist_sequencer

Built-in self-test controller for combinational netlists assembled from the standard-cell library (AND/OR/NAND/NOR/XOR/XNOR/INV/BUF cells).
- Generates pseudo-random input vectors with a Galois LFSR and holds each one on the device-under-test (DUT) inputs for a programmable settle time, sized to the accumulated cell path delays.
- Compresses the DUT outputs into a MISR signature and compares the result with an expected value.
- Sits between the generated circuit and the test harness; one instance per generated DUT.

## Interface
Parameters:
- IN_W, 8, DUT input width (≥2)
- OUT_W, 8, DUT output width (≥2)
- NUM_VEC, 256, vectors applied per run (≥1)
- SETTLE_CYC, 4, cycles each vector is held before capture (≥1)
- LFSR_POLY, 8'hB8, Galois LFSR feedback mask (IN_W bits)
- MISR_POLY, 8'h1D, MISR feedback mask (OUT_W bits)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a run; sampled only in IDLE or DONE
- seed  in  IN_W  initial LFSR value, sampled with start
- expected  in  OUT_W  golden signature, compared in DONE
- dut_in  out  IN_W  registered stimulus to DUT
- dut_out  in  OUT_W  DUT response
- busy  out  1  high from SETTLE through CAPTURE
- done  out  1  high while in DONE
- pass  out  1  (signature == expected), valid while done=1
- signature  out  OUT_W  current MISR value

Clock and reset: one clock; reset is synchronous and active-low.

## Operation
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE, DONE, start=1:
  - Load lfsr/dut_in with seed; a seed of 0 loads 1.
  - Clear signature and the vector counter.
  - Clear the settle counter.
  - Go to SETTLE.
- SETTLE: the settle counter increments each cycle; after SETTLE_CYC cycles in SETTLE, go to CAPTURE.
- CAPTURE (one cycle), all updates on this edge:
  - signature ← ((signature<<1) truncated to OUT_W) ^ (signature[OUT_W-1] ? MISR_POLY : 0) ^ dut_out.
  - lfsr/dut_in ← (lfsr>>1) ^ (lfsr[0] ? LFSR_POLY : 0).
  - Vector counter increments.
  - If this was vector NUM_VEC, go to DONE (dut_in advance is harmless); otherwise clear the settle counter and go to SETTLE.
- DONE: holds signature and dut_in; done=1 and pass is valid. Stays until start (restart) or reset.
- start while busy: ignored.
- Counter widths: vector counter $clog2(NUM_VEC+1) bits, settle counter $clog2(SETTLE_CYC+1) bits; neither wraps within a run.

## Timing
- Reset values: dut_in=0, signature=0, busy=0, done=0, pass=0, state IDLE.
- Reset asserted mid-run: returns to IDLE on the next edge, all outputs as above.
- start sampled at edge t: dut_in=seed visible after t, busy=1 from t.
- Each vector occupies SETTLE_CYC+1 cycles.
- DONE is entered at edge t + NUM_VEC·(SETTLE_CYC+1); done=1 and busy=0 from that edge.
- pass is registered: it is valid in the same cycle done first rises, computed from the final signature and the current expected. A change to expected while in DONE updates pass one cycle later.

## Configuration
- BIST_ABORT_EN defined:
  - Adds input abort (1 bit).
  - abort=1 in SETTLE or CAPTURE forces DONE on the next edge with pass=0, signature frozen.
  - abort in IDLE or DONE is ignored; start and abort together in IDLE favour start.
- BIST_ABORT_EN undefined: no abort port; runs always complete NUM_VEC vectors.

## Test plan
- Reset: drive rst_n=0 for 2 cycles mid-run -> dut_in=0, signature=0, busy=0, done=0, state IDLE.
- LFSR sequence: IN_W=8, seed=8'h01 -> dut_in shows 01, B8, 5C, 2E, each held 5 cycles (SETTLE_CYC=4).
- Signature: NUM_VEC=4, dut_out=dut_in, expected=8'h44 -> done after 20 cycles, signature=8'h44, pass=1; expected=8'h45 -> pass=0.
- Zero seed: seed=0, dut_out=0 -> first dut_in=01, signature=0, pass=1 with expected=0.
- Restart and ignore: pulse start during SETTLE -> no effect; start in DONE -> busy=1 next cycle, signature cleared, new run completes.
- With BIST_ABORT_EN: abort in the second vector's SETTLE -> done=1 next cycle, pass=0, signature=8'h01 held.

Source files
------------

// File: rtl/bist_sequencer.sv
// ============================================================================
// bist_sequencer : LFSR stimulus / MISR signature BIST controller for a
// combinational DUT. Optional abort input enabled by BIST_ABORT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_sequencer #(
  parameter int               IN_W       = 8,
  parameter int               OUT_W      = 8,
  parameter int               NUM_VEC    = 256,
  parameter int               SETTLE_CYC = 4,
  parameter logic [IN_W-1:0]  LFSR_POLY  = 8'hB8,
  parameter logic [OUT_W-1:0] MISR_POLY  = 8'h1D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IN_W-1:0]  seed,
  input  logic [OUT_W-1:0] expected,
`ifdef BIST_ABORT_EN
  input  logic             abort,
`endif
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature
);

  localparam int c_VEC_W = $clog2(NUM_VEC + 1);
  localparam int c_SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [c_VEC_W-1:0] c_VEC_LAST = c_VEC_W'(NUM_VEC - 1);
  localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [IN_W-1:0]    r_lfsr;
  logic [OUT_W-1:0]   r_sig;
  logic [c_VEC_W-1:0] r_vec;
  logic [c_SET_W-1:0] r_set;
  logic               r_pass;
  logic               r_aborted;

  logic               w_abort;
  logic               w_load;
  logic               w_capture;
  logic               w_last;
  logic               w_abort_now;
  logic [IN_W-1:0]    w_seed;
  logic [IN_W-1:0]    w_lfsr_next;
  logic [OUT_W-1:0]   w_sig_next;

`ifdef BIST_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // An all-zero Galois LFSR never leaves zero, so substitute 1.
  assign w_seed      = (seed == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : seed;
  assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_POLY : '0);
  assign w_sig_next  = {r_sig[OUT_W-2:0], 1'b0}
                     ^ (r_sig[OUT_W-1] ? MISR_POLY : '0)
                     ^ dut_out;

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    w_last       = 1'b0;
    w_abort_now  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_next_state = ST_SETTLE;
          w_load       = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_abort) begin
          w_next_state = ST_DONE;
          w_abort_now  = 1'b1;
        end else if (r_set == c_SET_LAST) begin
          w_next_state = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (w_abort) begin
          w_next_state = ST_DONE;
          w_abort_now  = 1'b1;
        end else begin
          w_capture = 1'b1;
          if (r_vec == c_VEC_LAST) begin
            w_last       = 1'b1;
            w_next_state = ST_DONE;
          end else begin
            w_next_state = ST_SETTLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_lfsr    <= '0;
      r_sig     <= '0;
      r_vec     <= '0;
      r_set     <= '0;
      r_pass    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_lfsr    <= w_seed;
        r_sig     <= '0;
        r_vec     <= '0;
        r_set     <= '0;
        r_pass    <= 1'b0;
        r_aborted <= 1'b0;
      end else if (w_abort_now) begin
        r_aborted <= 1'b1;
        r_pass    <= 1'b0;
      end else if (w_capture) begin
        r_sig  <= w_sig_next;
        r_lfsr <= w_lfsr_next;
        r_vec  <= r_vec + 1'b1;
        r_set  <= '0;
        // Registered so pass is already valid on the cycle done rises.
        r_pass <= w_last && (w_sig_next == expected);
      end else if (r_state == ST_SETTLE) begin
        r_set <= r_set + 1'b1;
      end else if (r_state == ST_DONE) begin
        r_pass <= !r_aborted && (r_sig == expected);
      end
    end
  end

  assign dut_in    = r_lfsr;
  assign signature = r_sig;
  assign pass      = r_pass;
  assign busy      = (r_state == ST_SETTLE) || (r_state == ST_CAPTURE);
  assign done      = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_bist_sequencer.sv
// ============================================================================
// tb_bist_sequencer : randomized self-checking bench for bist_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bist_sequencer;

  localparam int IN_W  = 8;
  localparam int OUT_W = 8;
  localparam int NV    = 4;
  localparam int SC    = 4;
  localparam int VLEN  = SC + 1;
  localparam int RUN   = NV * VLEN;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [IN_W-1:0]  seed = '0;
  logic [OUT_W-1:0] expected = '0;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [OUT_W-1:0] signature;
`ifdef BIST_ABORT_EN
  logic             abort = 1'b0;
`endif

  // Stand-in circuit: 0 = echo, 1 = nibble swap xor key, 2 = constant zero.
  int        mode = 0;
  logic [7:0] key = '0;

  int n_checks = 0;
  int n_fail   = 0;

  int m_vec[NV];
  int m_sig;

  always #5 clk = ~clk;

  assign dut_out = (mode == 0) ? dut_in :
                   (mode == 1) ? ({dut_in[3:0], dut_in[7:4]} ^ key) : 8'h00;

  bist_sequencer #(
    .IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(NV), .SETTLE_CYC(SC),
    .LFSR_POLY(8'hB8), .MISR_POLY(8'h1D)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .expected(expected),
`ifdef BIST_ABORT_EN
    .abort(abort),
`endif
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .signature(signature)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int circuit(input int x, input int md, input int k);
    if (md == 0) return x;
    if (md == 1) return (((x % 16) * 16) + (x / 16)) ^ k;
    return 0;
  endfunction

  // Whole-run reference: vector list and final signature from plain arithmetic.
  task automatic model_run(input int sd, input int md, input int k);
    int l;
    int s;
    l = (sd == 0) ? 1 : sd;
    s = 0;
    for (int i = 0; i < NV; i++) begin
      m_vec[i] = l;
      s = ((s * 2) % 256) ^ ((s >= 128) ? 'h1D : 0) ^ circuit(l, md, k);
      l = (l / 2) ^ ((l % 2 == 1) ? 'hB8 : 0);
    end
    m_sig = s;
  endtask

  task automatic do_run(input logic [7:0] sd, input int md, input logic [7:0] k,
                        input bit match, input bit poke);
    model_run(int'(sd), md, int'(k));
    mode     = md;
    key      = k;
    expected = match ? 8'(m_sig) : (8'(m_sig) ^ 8'($urandom_range(1, 255)));
    seed     = sd;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_sig_clear", 32'(signature), 32'h0);
    for (int c = 0; c < RUN; c++) begin
      check_eq("run_dut_in", 32'(dut_in), m_vec[c / VLEN]);
      check_eq("run_busy_done", {30'h0, busy, done}, 32'h2);
      if (poke && c == 2) begin
        start = 1'b1;
        seed  = ~sd;
      end
      if (c == 3) start = 1'b0;
      tick();
    end
    check_eq("end_busy_done", {30'h0, busy, done}, 32'h1);
    check_eq("end_signature", 32'(signature), m_sig);
    check_eq("end_pass", 32'(pass), 32'(match));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_dut_in", 32'(dut_in), 32'h0);
    check_eq("rst_signature", 32'(signature), 32'h0);
    check_eq("rst_busy_done_pass", {29'h0, busy, done, pass}, 32'h0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_busy_done", {30'h0, busy, done}, 32'h0);

    // Known answer: seed 01, echo circuit.
    do_run(8'h01, 0, 8'h00, 1'b1, 1'b1);
    check_eq("kat_vec1", m_vec[1], 32'hB8);
    check_eq("kat_signature", 32'(signature), 32'h44);
    expected = 8'h45;
    check_eq("kat_pass_hold", 32'(pass), 32'h1);
    tick();
    check_eq("kat_pass_exp45", 32'(pass), 32'h0);
    expected = 8'h44;
    tick();
    check_eq("kat_pass_exp44", 32'(pass), 32'h1);

    // Zero seed with an all-zero response.
    do_run(8'h00, 2, 8'h00, 1'b1, 1'b0);
    check_eq("zero_seed_sig", 32'(signature), 32'h0);

    for (int r = 0; r < 8; r++)
      do_run(8'($urandom), int'($urandom_range(0, 1)), 8'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Reset in the middle of a run.
    mode  = 0;
    seed  = 8'h33;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    check_eq("midrst_dut_in", 32'(dut_in), 32'h0);
    check_eq("midrst_signature", 32'(signature), 32'h0);
    check_eq("midrst_busy_done_pass", {29'h0, busy, done, pass}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("midrst_idle", {30'h0, busy, done}, 32'h0);

`ifdef BIST_ABORT_EN
    mode     = 0;
    expected = 8'h01;
    seed     = 8'h01;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy_done", {30'h0, busy, done}, 32'h1);
    check_eq("abort_pass", 32'(pass), 32'h0);
    check_eq("abort_signature", 32'(signature), 32'h01);
    repeat (2) tick();
    check_eq("abort_pass_held", 32'(pass), 32'h0);
    check_eq("abort_sig_held", 32'(signature), 32'h01);
`endif

    do_run(8'($urandom), 1, 8'($urandom), 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
